ysyx_24080006_id_buffer: RTL and testbench
==========================================

YSYX_24080006_ID_BUFFER -- requirements
Module: ysyx_24080006_id_buffer

Interface
REQ-001 SHALL have parameter DW, default 96, payload width in bits (decoded instruction plus pc plus operands).
REQ-002 SHALL have parameter DEPTH, default 2, number of entries (1..8, non-power-of-two legal).
REQ-003 SHALL have parameter BYPASS_POP, default 1; when 1, a push is allowed into a full buffer in the same cycle as a pop.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-007 SHALL have port hold, input, 1, hazard stall from decode that blocks acceptance.
REQ-008 SHALL have port in_valid, input, 1, upstream (IFU/IDU) entry present.
REQ-009 SHALL have port in_ready, output, 1, buffer accepts entry this cycle.
REQ-010 SHALL have port in_data, input, DW, upstream payload.
REQ-011 SHALL have port out_valid, output, 1, entry available to EXU.
REQ-012 SHALL have port out_ready, input, 1, EXU takes entry this cycle.
REQ-013 SHALL have port out_data, output, DW, oldest held payload.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1), number of held entries.
REQ-015 SHALL have port stall_cnt, output, 32, cycles with in_valid=1 and in_ready=0.

Function
REQ-016 SHALL store entries in a circular array with registered wr_ptr/rd_ptr, each wrapping from DEPTH-1 to 0.
REQ-017 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-018 SHALL drive out_valid = (count != 0) && !flush.
REQ-019 SHALL drive in_ready = !hold && !flush && reset && ((count < DEPTH) || (BYPASS_POP && out_ready && count == DEPTH)).
REQ-020 SHALL have no combinational path from in_data or in_valid to any output; an entry pushed in cycle N is first visible at out_valid/out_data in cycle N+1 (latency 1).
REQ-021 SHALL present out_data = entry at rd_ptr, held stable while out_valid=1 and out_ready=0.
REQ-022 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 SHALL, on simultaneous push and pop with count=DEPTH (BYPASS_POP=1), write the new entry into the slot freed by the pop and advance both pointers.
REQ-024 SHALL, with BYPASS_POP=0 and DEPTH=1, sustain at most one transfer per two cycles.
REQ-025 SHALL preserve FIFO order; entries leave in push order with no loss or duplication.
REQ-026 SHALL, in a flush cycle, perform no push or pop, and set count, wr_ptr and rd_ptr to 0 at the next edge; flush overrides hold, in_valid and out_ready.
REQ-027 SHALL, while hold=1, accept nothing but continue popping normally.
REQ-028 SHALL increment stall_cnt each cycle with in_valid=1 and in_ready=0, saturating at 0xFFFFFFFF; flush does not clear it.
REQ-029 SHALL never overflow (push when full without pop) or underflow (pop when empty); the bench asserts both.

Reset
REQ-030 SHALL, while reset=0, asynchronously force count=0, wr_ptr=0, rd_ptr=0, stall_cnt=0, out_valid=0, in_ready=0.
REQ-031 SHALL leave payload storage unreset; out_data is don't-care while out_valid=0.
REQ-032 SHALL, on reset asserted mid-transfer, discard all held entries; the first cycle after release has count=0 and accepts a new push if hold=0.

Verification
REQ-033 Back-to-back: DEPTH=2, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on cycles N+1..N+3, count stays 1.
REQ-034 Fill/full: DEPTH=2, out_ready=0, push 3 entries -> count=2 after 2 pushes, in_ready=0 on the third, stall_cnt increments by 1 per blocked cycle.
REQ-035 Bypass on full: DEPTH=2 full, BYPASS_POP=1, out_ready=1 and in_valid=1 -> in_ready=1, count stays 2, order preserved; with BYPASS_POP=0 -> in_ready=0.
REQ-036 Flush: count=2, assert flush with in_valid=1, out_ready=1 -> no transfer that cycle, next cycle count=0, out_valid=0.
REQ-037 Hold: hold=1 with count=1, out_ready=1 -> entry pops, in_ready=0, count=0 next cycle.
REQ-038 Async reset: drop reset mid-stream between clock edges -> count=0, out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/ysyx_24080006_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_id_buffer
// Description : ID->EX elastic buffer. Circular FIFO with registered outputs,
//               flush/hold control and a saturating upstream-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080006_id_buffer #(
    parameter int DW         = 96,
    parameter int DEPTH      = 2,
    parameter int BYPASS_POP = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           hold,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DW-1:0]                  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DW-1:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [31:0]                    stall_cnt
);

    localparam int                CW       = $clog2(DEPTH + 1);
    localparam int                PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]     C_FULL   = CW'(DEPTH);
    localparam logic [PW-1:0]     C_LAST   = PW'(DEPTH - 1);
    localparam bit                C_BYPASS = (BYPASS_POP != 0);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_stall_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_stall;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        return (ptr == C_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);

    // Readiness depends only on state and downstream controls, never on in_valid/in_data.
    assign out_valid = !w_empty && !flush;
    assign in_ready  = !hold && !flush && reset &&
                       (!w_full || (C_BYPASS && out_ready && w_full));

    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_stall   = in_valid && !in_ready;

    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; a full-buffer bypass lands in the slot the pop frees.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24080006_id_buffer
// Description : Directed self-checking bench for the ID->EX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ysyx_24080006_id_buffer;

    localparam int DW = 96;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          hold;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    count;
    logic [31:0]   stall_cnt;

    logic          nb_in_valid;
    logic          nb_in_ready;
    logic [DW-1:0] nb_in_data;
    logic          nb_out_valid;
    logic          nb_out_ready;
    logic [DW-1:0] nb_out_data;
    logic [1:0]    nb_count;
    logic [31:0]   nb_stall_cnt;

    int  n_vec  = 0;
    int  n_miss = 0;
    bit  mon_on = 1'b0;

    always #5 clock = ~clock;

    ysyx_24080006_id_buffer #(.DW(DW), .DEPTH(2), .BYPASS_POP(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    ysyx_24080006_id_buffer #(.DW(DW), .DEPTH(2), .BYPASS_POP(0)) dut_nb (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (nb_in_valid),
        .in_ready  (nb_in_ready),
        .in_data   (nb_in_data),
        .out_valid (nb_out_valid),
        .out_ready (nb_out_ready),
        .out_data  (nb_out_data),
        .count     (nb_count),
        .stall_cnt (nb_stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Overflow / underflow watch on the main instance, sampled mid-cycle.
    always @(negedge clock) begin
        if (mon_on && reset) begin
            chk("no_ovf", {127'd0, in_valid && in_ready && (count == 2'd2) && !(out_valid && out_ready)}, 128'd0);
            chk("no_udf", {127'd0, out_valid && out_ready && (count == 2'd0)}, 128'd0);
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        nb_in_valid = 1'b0; nb_out_ready = 1'b0; nb_in_data = '0;

        // reset state
        #2 in_valid = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 0);
        chk("rst_stall", stall_cnt, 0);
        cyc(); #2;
        chk("rst_stall_edge", stall_cnt, 0);
        cyc();
        reset = 1'b1; in_valid = 1'b0; mon_on = 1'b1;
        #2;
        chk("rel_iready", in_ready, 1);
        chk("rel_count", count, 0);

        // back-to-back streaming
        cyc(); out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h1; #2;
        chk("b2b_iready", in_ready, 1);
        chk("b2b_ovalid0", out_valid, 0);
        cyc(); in_data = 96'h2; #2;
        chk("b2b_ovalid1", out_valid, 1);
        chk("b2b_data1", out_data, 96'h1);
        chk("b2b_count1", count, 1);
        cyc(); in_data = 96'h3; #2;
        chk("b2b_data2", out_data, 96'h2);
        chk("b2b_count2", count, 1);
        cyc(); in_valid = 1'b0; #2;
        chk("b2b_data3", out_data, 96'h3);
        chk("b2b_count3", count, 1);
        cyc(); #2;
        chk("b2b_drained", out_valid, 0);
        chk("b2b_count0", count, 0);

        // fill to full, then blocked pushes
        cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h10; #2;
        cyc(); in_data = 96'h11; #2;
        chk("fill_count1", count, 1);
        cyc(); in_data = 96'h12; #2;
        chk("fill_count2", count, 2);
        chk("fill_iready", in_ready, 0);
        chk("fill_stall0", stall_cnt, 0);
        cyc(); #2;
        chk("fill_stall1", stall_cnt, 1);
        chk("fill_head", out_data, 96'h10);

        // bypass push into a full buffer
        cyc(); out_ready = 1'b1; #2;
        chk("byp_stall2", stall_cnt, 2);
        chk("byp_iready", in_ready, 1);
        cyc(); in_valid = 1'b0; #2;
        chk("byp_count", count, 2);
        chk("byp_head", out_data, 96'h11);

        // hold blocks acceptance but not popping
        cyc(); hold = 1'b1; in_valid = 1'b1; in_data = 96'h55; #2;
        chk("hold_iready", in_ready, 0);
        chk("hold_ovalid", out_valid, 1);
        chk("hold_head", out_data, 96'h12);
        chk("hold_count", count, 1);
        cyc(); hold = 1'b0; in_valid = 1'b0; #2;
        chk("hold_count0", count, 0);
        chk("hold_ovalid0", out_valid, 0);
        chk("hold_stall3", stall_cnt, 3);

        // flush overrides everything
        cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h20;
        cyc(); in_data = 96'h21;
        cyc(); flush = 1'b1; out_ready = 1'b1; in_data = 96'h22; #2;
        chk("fl_count2", count, 2);
        chk("fl_ovalid", out_valid, 0);
        chk("fl_iready", in_ready, 0);
        cyc(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #2;
        chk("fl_count0", count, 0);
        chk("fl_ovalid0", out_valid, 0);
        chk("fl_stall4", stall_cnt, 4);
        cyc(); in_valid = 1'b1; in_data = 96'h23;
        cyc(); in_valid = 1'b0; #2;
        chk("fl_repush", out_data, 96'h23);
        chk("fl_recount", count, 1);

        // asynchronous reset between edges
        cyc(); in_valid = 1'b1; in_data = 96'h30;
        cyc(); in_valid = 1'b0; #1;
        chk("ar_pre_count", count, 2);
        #1 reset = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_ovalid", out_valid, 0);
        chk("ar_iready", in_ready, 0);
        chk("ar_stall", stall_cnt, 0);
        cyc(); reset = 1'b1; in_valid = 1'b1; in_data = 96'h40; #2;
        chk("ar_rel_iready", in_ready, 1);
        chk("ar_rel_count", count, 0);
        cyc(); in_valid = 1'b0; #2;
        chk("ar_rel_data", out_data, 96'h40);
        chk("ar_rel_count1", count, 1);
        cyc(); out_ready = 1'b1;
        cyc(); out_ready = 1'b0; #2;
        chk("ar_drained", count, 0);

        // no-bypass instance: full buffer refuses push even with out_ready
        cyc(); nb_in_valid = 1'b1; nb_in_data = 96'hA0;
        cyc(); nb_in_data = 96'hA1;
        cyc(); nb_out_ready = 1'b1; nb_in_data = 96'hA2; #2;
        chk("nb_count2", nb_count, 2);
        chk("nb_iready", nb_in_ready, 0);
        chk("nb_head", nb_out_data, 96'hA0);
        cyc(); #2;
        chk("nb_count1", nb_count, 1);
        chk("nb_iready1", nb_in_ready, 1);
        chk("nb_head1", nb_out_data, 96'hA1);
        cyc(); nb_in_valid = 1'b0; #2;
        chk("nb_head2", nb_out_data, 96'hA2);
        chk("nb_count1b", nb_count, 1);
        cyc(); nb_out_ready = 1'b0; #2;
        chk("nb_empty", nb_count, 0);

        mon_on = 1'b0;
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
